// File: rtl/y_prog_loader.sv
// -----------------------------------------------------------------------------
// y_prog_loader
//
// Writer side of the instruction memory. A host/debug stream of 32-bit
// instruction words, offered on a valid/ready interface, is written to
// consecutive word addresses starting at base_addr. After the final write has
// been issued, the loader drives INT high for INT_CYCLES cycles with
// entryPoint set to the latched entry address, so the PC jumps to the loaded
// program. It then pulses done and returns to IDLE.
//
// Optional feature (compile-time macro LOADER_CHECKSUM_EN):
//   Adds the expected_sum input. A 32-bit modulo sum of the accepted words is
//   compared with it at the end of the load. On a mismatch the kick is
//   skipped, and err and done pulse together.
//
// Parameters:
//   CNT_W       width of word_count and the internal word index (<= 32)
//   INT_CYCLES  number of cycles INT is held high during the kick (>= 1)
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          load request, honoured only in IDLE
//   base_addr      byte address of the first word (must be word aligned)
//   entry_addr     PC target driven on entryPoint during the kick
//   word_count     number of words to load (must be non-zero)
//   expected_sum   checksum of the stream (LOADER_CHECKSUM_EN only)
//   in_valid       stream word valid
//   in_data        stream word
//   in_ready       loader accepts a word this cycle
//   mem_addr       instruction memory write address
//   mem_wdata      instruction memory write data
//   mem_write      instruction memory write strobe, one cycle per word
//   INT            to chip INT; selects entryPoint into the PC
//   entryPoint     to chip entryPoint
//   busy           high in every state except IDLE
//   done           one-cycle pulse at the end of the sequence
//   err            one-cycle pulse on a rejected start or a checksum mismatch
// -----------------------------------------------------------------------------
module y_prog_loader #(
  parameter int CNT_W      = 16,
  parameter int INT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [31:0]      entry_addr,
  input  logic [CNT_W-1:0] word_count,
`ifdef LOADER_CHECKSUM_EN
  input  logic [31:0]      expected_sum,
`endif
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_write,
  output logic             INT,
  output logic [31:0]      entryPoint,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // The kick counter only has to count 0 .. INT_CYCLES-1.
  localparam int KW = (INT_CYCLES > 1) ? $clog2(INT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_KICK,
    S_DONE
  } state_e;

  state_e           state_q,     state_d;
  logic [31:0]      base_q,      base_d;
  logic [31:0]      entry_q,     entry_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [CNT_W-1:0] idx_q,       idx_d;
  logic [KW-1:0]    kick_q,      kick_d;
  logic [31:0]      mem_addr_q,  mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             mem_write_q, mem_write_d;
  logic             err_q,       err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]      sum_q,       sum_d;
  logic [31:0]      exp_q,       exp_d;
`endif

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    base_d      = base_q;
    entry_d     = entry_q;
    count_d     = count_q;
    idx_d       = idx_q;
    kick_d      = kick_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = 1'b0;
    err_d       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    exp_d       = exp_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (base_addr[1:0] != 2'b00 || word_count == '0) begin
            err_d = 1'b1;
          end else begin
            base_d  = base_addr;
            entry_d = entry_addr;
            count_d = word_count;
            idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = '0;
            exp_d   = expected_sum;
`endif
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          // The write is registered, so it appears exactly one cycle after
          // the handshake; the address wraps modulo 2^32.
          mem_write_d = 1'b1;
          mem_addr_d  = base_q + (32'(idx_q) << 2);
          mem_wdata_d = in_data;
          idx_d       = idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d       = sum_q + in_data;
`endif
          if (idx_q == count_q - 1'b1) begin
            state_d = S_DRAIN;
          end
        end
      end

      // The last registered write is on the bus during this cycle, which
      // keeps mem_write and INT from ever overlapping.
      S_DRAIN: begin
        kick_d  = '0;
        state_d = S_KICK;
`ifdef LOADER_CHECKSUM_EN
        if (sum_q != exp_q) begin
          // Registered err lines up with the DONE cycle.
          err_d   = 1'b1;
          state_d = S_DONE;
        end
`endif
      end

      S_KICK: begin
        if (kick_q == KW'(INT_CYCLES - 1)) begin
          state_d = S_DONE;
        end else begin
          kick_d = kick_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values that were present before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      entry_q     <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      kick_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
      exp_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      entry_q     <= entry_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      kick_q      <= kick_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      err_q       <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      exp_q       <= exp_d;
`endif
    end
  end

  // Every output comes straight from a flop or decodes the state register,
  // so reset drives them all to 0 immediately.
  assign in_ready   = (state_q == S_LOAD);
  assign INT        = (state_q == S_KICK);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_write  = mem_write_q;
  // The entry address is latched on an accepted start; it is therefore stable
  // from the first INT cycle until the next accepted start or reset.
  assign entryPoint = entry_q;

endmodule

// File: tb/tb_y_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_y_prog_loader
//
// Directed testbench for y_prog_loader. It samples outputs 1 ns after each
// rising edge and drives inputs at the same point. Expected values are
// written out by hand for each cycle.
// -----------------------------------------------------------------------------
module tb_y_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] entry_addr;
  logic [15:0] word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] expected_sum;
`endif
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        int_o;
  logic [31:0] entry_point;
  logic        busy;
  logic        done;
  logic        err;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  y_prog_loader #(.CNT_W(16), .INT_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .entry_addr   (entry_addr),
    .word_count   (word_count),
`ifdef LOADER_CHECKSUM_EN
    .expected_sum (expected_sum),
`endif
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_write    (mem_write),
    .INT          (int_o),
    .entryPoint   (entry_point),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the control outputs every cycle. Address/data are checked on
  // write cycles, and entryPoint while INT is high.
  task automatic expect_st(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic intr, input logic [31:0] ep,
                           input logic bsy, input logic dn, input logic er, input logic rdy);
    check({tag, ".mem_write"}, mem_write, we);
    check({tag, ".INT"},       int_o,     intr);
    check({tag, ".busy"},      busy,      bsy);
    check({tag, ".done"},      done,      dn);
    check({tag, ".err"},       err,       er);
    check({tag, ".in_ready"},  in_ready,  rdy);
    if (we) begin
      check({tag, ".mem_addr"},  mem_addr,  addr);
      check({tag, ".mem_wdata"}, mem_wdata, data);
    end
    if (intr) check({tag, ".entryPoint"}, entry_point, ep);
  endtask

  task automatic do_start(input logic [31:0] b, input logic [31:0] e, input logic [15:0] c);
    start      = 1'b1;
    base_addr  = b;
    entry_addr = e;
    word_count = c;
    tick();
    start      = 1'b0;
  endtask

  // Kick tail shared by every successful load: two INT cycles, DONE, IDLE.
  task automatic expect_kick(input string tag, input logic [31:0] ep);
    expect_st({tag, ".kick0"}, 0, 0, 0, 1, ep, 1, 0, 0, 0);
    tick();
    expect_st({tag, ".kick1"}, 0, 0, 0, 1, ep, 1, 0, 0, 0);
    tick();
    expect_st({tag, ".done"},  0, 0, 0, 0, 0,  1, 1, 0, 0);
    tick();
    expect_st({tag, ".idle"},  0, 0, 0, 0, 0,  0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; entry_addr = '0; word_count = '0;
    in_valid = 1'b0; in_data = '0;
`ifdef LOADER_CHECKSUM_EN
    expected_sum = '0;
`endif
    #12;
    // Reset state: everything at zero.
    check("rst.entryPoint", entry_point, 32'h0);
    check("rst.mem_addr",   mem_addr,    32'h0);
    expect_st("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1) Three words, in_valid held high.
    do_start(32'h100, 32'h100, 16'd3);
    expect_st("t1.load", 0, 0, 0, 0, 0, 1, 0, 0, 1);
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    expect_st("t1.w0", 1, 32'h100, 32'hA, 0, 0, 1, 0, 0, 1);
    in_data = 32'hB;
    tick();
    expect_st("t1.w1", 1, 32'h104, 32'hB, 0, 0, 1, 0, 0, 1);
    in_data = 32'hC;
    tick();
    expect_st("t1.w2", 1, 32'h108, 32'hC, 0, 0, 1, 0, 0, 0);
    in_valid = 1'b0;
    tick();
    expect_kick("t1", 32'h100);

    // 2) Same load with in_valid toggling 1,0,1,0,1; a start during LOAD is ignored.
    do_start(32'h100, 32'h100, 16'd3);
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    expect_st("t2.w0", 1, 32'h100, 32'hA, 0, 0, 1, 0, 0, 1);
    in_valid = 1'b0; in_data = 32'h5555;
    start = 1'b1; base_addr = 32'h102; word_count = 16'd0;
    tick();
    start = 1'b0;
    expect_st("t2.gap0", 0, 0, 0, 0, 0, 1, 0, 0, 1);
    check("t2.gap0.hold_addr", mem_addr,  32'h100);
    check("t2.gap0.hold_data", mem_wdata, 32'hA);
    in_valid = 1'b1; in_data = 32'hB;
    tick();
    expect_st("t2.w1", 1, 32'h104, 32'hB, 0, 0, 1, 0, 0, 1);
    in_valid = 1'b0;
    tick();
    expect_st("t2.gap1", 0, 0, 0, 0, 0, 1, 0, 0, 1);
    in_valid = 1'b1; in_data = 32'hC;
    tick();
    expect_st("t2.w2", 1, 32'h108, 32'hC, 0, 0, 1, 0, 0, 0);
    in_valid = 1'b0;
    tick();
    expect_kick("t2", 32'h100);

    // 3) Rejected starts: misaligned base, then zero count.
    in_valid = 1'b1;  // ignored outside LOAD
    do_start(32'h102, 32'h200, 16'd3);
    expect_st("t3.misalign", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    expect_st("t3.after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_start(32'h100, 32'h200, 16'd0);
    expect_st("t3.zero", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    in_valid = 1'b0;
    tick();
    expect_st("t3.after2", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 4) Address wrap past 0xFFFFFFFC.
    do_start(32'hFFFF_FFFC, 32'h40, 16'd2);
    in_valid = 1'b1; in_data = 32'h1111;
    tick();
    expect_st("t4.w0", 1, 32'hFFFF_FFFC, 32'h1111, 0, 0, 1, 0, 0, 1);
    in_data = 32'h2222;
    tick();
    expect_st("t4.w1", 1, 32'h0, 32'h2222, 0, 0, 1, 0, 0, 0);
    in_valid = 1'b0;
    tick();
    expect_kick("t4", 32'h40);

    // 5) Reset after 2 of 4 words, then a fresh single-word load.
    do_start(32'h200, 32'h200, 16'd4);
    in_valid = 1'b1; in_data = 32'h77;
    tick();
    in_data = 32'h88;
    tick();
    expect_st("t5.w1", 1, 32'h204, 32'h88, 0, 0, 1, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    expect_st("t5.rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t5.rst.entryPoint", entry_point, 32'h0);
    check("t5.rst.mem_addr",   mem_addr,    32'h0);
    tick();
    tick();
    expect_st("t5.rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    expect_st("t5.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    do_start(32'h300, 32'h300, 16'd1);
    in_valid = 1'b1; in_data = 32'hDD;
    tick();
    expect_st("t5.w0", 1, 32'h300, 32'hDD, 0, 0, 1, 0, 0, 0);
    in_valid = 1'b0;
    tick();
    expect_kick("t5", 32'h300);

`ifdef LOADER_CHECKSUM_EN
    // 6) Checksum match: kick happens.
    expected_sum = 32'd6;
    do_start(32'h400, 32'h400, 16'd3);
    in_valid = 1'b1; in_data = 32'd1;
    tick();
    in_data = 32'd2;
    tick();
    in_data = 32'd3;
    tick();
    expect_st("t6.w2", 1, 32'h408, 32'd3, 0, 0, 1, 0, 0, 0);
    in_valid = 1'b0;
    tick();
    expect_kick("t6", 32'h400);

    // 7) Checksum mismatch: no INT, err and done together.
    expected_sum = 32'd7;
    do_start(32'h400, 32'h500, 16'd3);
    in_valid = 1'b1; in_data = 32'd1;
    tick();
    in_data = 32'd2;
    tick();
    in_data = 32'd3;
    tick();
    expect_st("t7.w2", 1, 32'h408, 32'd3, 0, 0, 1, 0, 0, 0);
    in_valid = 1'b0;
    tick();
    expect_st("t7.done", 0, 0, 0, 0, 0, 1, 1, 1, 0);
    tick();
    expect_st("t7.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
